// File: rtl/clock_monitor.sv
// ---------------------------------------------------------------------------
// clock_monitor
//
// Measures a clock-like signal (clk_in) by sampling it as data in the
// masterclk domain. Reports the rise-to-rise period and the high phase in
// masterclk cycles, tracks min/max period since the last clear, flags periods
// outside [lo_limit, hi_limit], and declares loss of clock when no rising edge
// arrives within TIMEOUT cycles.
//
// Ports:
//   masterclk    in   system clock, all logic on its rising edge
//   reset_n      in   asynchronous active-low reset
//   clk_in       in   monitored signal, asynchronous to masterclk
//   clear        in   one-cycle pulse: resets min/max, lost_sticky, edge_count
//   lo_limit     in   lowest acceptable period
//   hi_limit     in   highest acceptable period
//   period       out  last measured rise-to-rise period
//   high_time    out  last measured high phase
//   period_valid out  one-cycle pulse when period updates
//   period_min   out  smallest period since clear (all ones when none)
//   period_max   out  largest period since clear
//   out_of_range out  last period below lo_limit or above hi_limit
//   clk_lost     out  high while the monitor is in the LOST state
//   lost_sticky  out  set on entry to LOST, cleared only by clear
//   edge_count   out  number of rising edges seen, wraps
// ---------------------------------------------------------------------------
module clock_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16,
  parameter int TIMEOUT     = 1000
) (
  input  logic                 masterclk,
  input  logic                 reset_n,
  input  logic                 clk_in,
  input  logic                 clear,
  input  logic [CNT_WIDTH-1:0] lo_limit,
  input  logic [CNT_WIDTH-1:0] hi_limit,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 period_valid,
  output logic [CNT_WIDTH-1:0] period_min,
  output logic [CNT_WIDTH-1:0] period_max,
  output logic                 out_of_range,
  output logic                 clk_lost,
  output logic                 lost_sticky,
  output logic [31:0]          edge_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOST    = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Synchronizer chain plus one delay flop for edge detection
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   d_reg;
  logic                   s;
  logic                   rise;
  logic                   fall;

  always_ff @(posedge masterclk or negedge reset_n) begin
    if (!reset_n) sync_reg[0] <= 1'b0;
    else          sync_reg[0] <= clk_in;
  end

  generate
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge masterclk or negedge reset_n) begin
        if (!reset_n) sync_reg[gi] <= 1'b0;
        else          sync_reg[gi] <= sync_reg[gi-1];
      end
    end
  endgenerate

  assign s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge masterclk or negedge reset_n) begin
    if (!reset_n) d_reg <= 1'b0;
    else          d_reg <= s;
  end

  assign rise = s & ~d_reg;
  assign fall = ~s & d_reg;

  // -------------------------------------------------------------------------
  // Period FSM
  // -------------------------------------------------------------------------
  state_t               state_reg, state_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic                 update;   // a full period was just measured
  logic                 loss;     // timeout expired this cycle

  always_ff @(posedge masterclk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    update     = 1'b0;
    loss       = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (rise) begin
          cnt_next   = CNT_ONE;
          state_next = MEASURE;
        end
      end
      MEASURE: begin
        // A rise in the timeout cycle still counts as a valid period.
        if (rise) begin
          update   = 1'b1;
          cnt_next = CNT_ONE;
        end else if (cnt_reg == TIMEOUT_CNT) begin
          loss       = 1'b1;
          cnt_next   = '0;
          state_next = LOST;
        end else if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      LOST: begin
        cnt_next = '0;
        if (rise) begin
          cnt_next   = CNT_ONE;
          state_next = MEASURE;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign clk_lost = (state_reg == LOST);

  // -------------------------------------------------------------------------
  // High-time counter: restarts on every rise, captured on fall while measuring
  // -------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] hcnt_reg;

  always_ff @(posedge masterclk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_reg  <= '0;
      high_time <= '0;
    end else begin
      if (rise)                        hcnt_reg <= CNT_ONE;
      else if (s && hcnt_reg != CNT_MAX) hcnt_reg <= hcnt_reg + CNT_ONE;
      if (fall && state_reg == MEASURE) high_time <= hcnt_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Measurement outputs and statistics
  // -------------------------------------------------------------------------
  always_ff @(posedge masterclk or negedge reset_n) begin
    if (!reset_n) begin
      period       <= '0;
      period_valid <= 1'b0;
      out_of_range <= 1'b0;
      period_min   <= CNT_MAX;
      period_max   <= '0;
      lost_sticky  <= 1'b0;
      edge_count   <= '0;
    end else begin
      period_valid <= update;
      if (update) begin
        period       <= cnt_reg;
        out_of_range <= (cnt_reg < lo_limit) | (cnt_reg > hi_limit);
      end

      // clear restarts the statistics, but a sample arriving in the same
      // cycle is folded into the fresh statistics.
      if (clear && update) begin
        period_min <= cnt_reg;
        period_max <= cnt_reg;
      end else if (clear) begin
        period_min <= CNT_MAX;
        period_max <= '0;
      end else if (update) begin
        if (cnt_reg < period_min) period_min <= cnt_reg;
        if (cnt_reg > period_max) period_max <= cnt_reg;
      end

      // A loss coinciding with clear must not be forgotten.
      if (loss)       lost_sticky <= 1'b1;
      else if (clear) lost_sticky <= 1'b0;

      if (clear)     edge_count <= rise ? 32'd1 : 32'd0;
      else if (rise) edge_count <= edge_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_clock_monitor.sv
// ---------------------------------------------------------------------------
// tb_clock_monitor
//
// Drives clk_in as a sequence of (high, low) phases, directed then random.
// A reference model works on edge timestamps: period = time between
// successive rises, high time = time from rise to fall, loss = no rise within
// TIMEOUT of the previous one. Every measured period pushes an expected
// record into a scoreboard queue; a monitor pops it when period_valid is seen.
// Level outputs are compared against the model every cycle.
// ---------------------------------------------------------------------------
module tb_clock_monitor;

  localparam int SYNC = 2;
  localparam int CW   = 16;
  localparam int TO   = 100;

  logic          masterclk = 1'b0;
  logic          reset_n;
  logic          clk_in;
  logic          clear;
  logic [CW-1:0] lo_limit;
  logic [CW-1:0] hi_limit;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          period_valid;
  logic [CW-1:0] period_min;
  logic [CW-1:0] period_max;
  logic          out_of_range;
  logic          clk_lost;
  logic          lost_sticky;
  logic [31:0]   edge_count;

  clock_monitor #(.SYNC_STAGES(SYNC), .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .masterclk    (masterclk),
    .reset_n      (reset_n),
    .clk_in       (clk_in),
    .clear        (clear),
    .lo_limit     (lo_limit),
    .hi_limit     (hi_limit),
    .period       (period),
    .high_time    (high_time),
    .period_valid (period_valid),
    .period_min   (period_min),
    .period_max   (period_max),
    .out_of_range (out_of_range),
    .clk_lost     (clk_lost),
    .lost_sticky  (lost_sticky),
    .edge_count   (edge_count)
  );

  always #5 masterclk = ~masterclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model (timestamp based)
  // -------------------------------------------------------------------------
  typedef struct {
    logic [CW-1:0] per;
    logic [CW-1:0] hi_t;
    logic [CW-1:0] mn;
    logic [CW-1:0] mx;
    logic          oor;
    logic [31:0]   ec;
  } txn_t;

  txn_t sb[$];

  logic [CW-1:0] exp_period    = '0;
  logic [CW-1:0] exp_high      = '0;
  logic [CW-1:0] exp_min       = '1;
  logic [CW-1:0] exp_max       = '0;
  logic          exp_oor       = 1'b0;
  logic          exp_lost      = 1'b0;
  logic          exp_sticky    = 1'b0;
  logic [31:0]   exp_ec        = '0;

  initial begin : model
    int  t;
    int  ref_t;
    int  hrise_t;
    int  per;
    bit  have_ref;
    bit  rise;
    bit  fall;
    bit  upd;
    bit  loss;
    bit  hist [SYNC+1];
    txn_t tx;
    t = 0; ref_t = 0; hrise_t = 0; have_ref = 0;
    foreach (hist[i]) hist[i] = 0;
    forever begin
      @(posedge masterclk);
      if (!reset_n) begin
        foreach (hist[i]) hist[i] = 0;
        have_ref   = 0;
        exp_period = '0; exp_high = '0; exp_min = '1; exp_max = '0;
        exp_oor    = 0;  exp_lost = 0;  exp_sticky = 0; exp_ec = '0;
      end else begin
        // clk_in seen SYNC edges ago versus one edge before that
        rise = hist[SYNC-1] && !hist[SYNC];
        fall = !hist[SYNC-1] && hist[SYNC];
        upd  = 0;
        loss = 0;
        per  = 0;
        if (fall && have_ref && !exp_lost) exp_high = CW'(t - hrise_t);
        if (rise) begin
          if (have_ref && !exp_lost) begin
            upd = 1;
            per = t - ref_t;
          end
          have_ref = 1;
          exp_lost = 0;
          ref_t    = t;
          hrise_t  = t;
        end else if (have_ref && !exp_lost && (t - ref_t) == TO) begin
          loss     = 1;
          exp_lost = 1;
        end
        if (clear) begin
          exp_min    = '1;
          exp_max    = '0;
          exp_ec     = '0;
          exp_sticky = 0;
        end
        if (loss) exp_sticky = 1;
        if (rise) exp_ec = exp_ec + 32'd1;
        if (upd) begin
          exp_period = CW'(per);
          exp_oor    = (per < int'(lo_limit)) || (per > int'(hi_limit));
          if (per < int'(exp_min)) exp_min = CW'(per);
          if (per > int'(exp_max)) exp_max = CW'(per);
          tx.per = exp_period; tx.hi_t = exp_high; tx.mn = exp_min;
          tx.mx  = exp_max;    tx.oor  = exp_oor;  tx.ec = exp_ec;
          sb.push_back(tx);
        end
        for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = clk_in;
        t++;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Monitor: scoreboard pops on period_valid, level outputs every cycle
  // -------------------------------------------------------------------------
  initial begin : monitor
    txn_t tx;
    forever begin
      @(negedge masterclk);
      if (period_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          tx = sb.pop_front();
          check("sb_period", 32'(period), 32'(tx.per));
          check("sb_high_time", 32'(high_time), 32'(tx.hi_t));
          check("sb_min", 32'(period_min), 32'(tx.mn));
          check("sb_max", 32'(period_max), 32'(tx.mx));
          check("sb_out_of_range", 32'(out_of_range), 32'(tx.oor));
          check("sb_edge_count", edge_count, tx.ec);
          $display("txn t=%0t period=%0d high=%0d min=%0d max=%0d oor=%0d edges=%0d",
                   $time, period, high_time, period_min, period_max, out_of_range, edge_count);
        end
      end else begin
        check("valid_pending", 32'(period_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) void'(sb.pop_front());
      end
      check("period", 32'(period), 32'(exp_period));
      check("high_time", 32'(high_time), 32'(exp_high));
      check("period_min", 32'(period_min), 32'(exp_min));
      check("period_max", 32'(period_max), 32'(exp_max));
      check("out_of_range", 32'(out_of_range), 32'(exp_oor));
      check("clk_lost", 32'(clk_lost), 32'(exp_lost));
      check("lost_sticky", 32'(lost_sticky), 32'(exp_sticky));
      check("edge_count", edge_count, exp_ec);
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  task automatic tick();
    @(negedge masterclk);
    #1;
    clear = 1'b0;
  endtask

  // One clk_in cycle; optional clear lands on the cycle this rise is processed.
  task automatic one_period(input int high, input int low, input bit clr);
    clk_in = 1'b1;
    for (int i = 0; i < high; i++) begin
      tick();
      if (clr && i == 1) clear = 1'b1;
    end
    clk_in = 1'b0;
    for (int i = 0; i < low; i++) tick();
  endtask

  initial begin : stim
    reset_n  = 1'b0;
    clk_in   = 1'b0;
    clear    = 1'b0;
    lo_limit = CW'(18);
    hi_limit = CW'(22);
    repeat (3) tick();
    check("rst_period_min", 32'(period_min), 32'hFFFF);
    check("rst_edge_count", edge_count, 32'd0);
    reset_n = 1'b1;
    repeat (3) tick();

    // steady 20-cycle clock, 50% duty, then 20/25/15
    repeat (5) one_period(10, 10, 1'b0);
    one_period(10, 10, 1'b0);
    one_period(10, 15, 1'b0);
    one_period(10, 5, 1'b0);
    one_period(10, 10, 1'b0);

    // loss while held high, fall during LOST, restart
    clk_in = 1'b1;
    repeat (150) tick();
    clk_in = 1'b0;
    repeat (10) tick();
    repeat (3) one_period(10, 10, 1'b0);
    clear = 1'b1;
    tick();

    // clear coinciding with a period-30 update
    one_period(15, 15, 1'b0);
    one_period(10, 10, 1'b1);
    one_period(10, 10, 1'b0);

    // asynchronous reset mid-period, then period 8
    clk_in = 1'b1;
    repeat (3) tick();
    reset_n = 1'b0;
    clk_in  = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (5) one_period(4, 4, 1'b0);

    // rise exactly at the timeout cycle, then one cycle too late
    one_period(50, 50, 1'b0);
    one_period(50, 50, 1'b0);
    one_period(50, 51, 1'b0);
    repeat (3) one_period(5, 5, 1'b0);

    // random phases, limits and clears
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        lo_limit = CW'($urandom_range(1, 80));
        hi_limit = lo_limit + CW'($urandom_range(0, 60));
      end
      one_period($urandom_range(1, 60), $urandom_range(1, 60), $urandom_range(0, 7) == 0);
    end

    repeat (20) tick();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_monitor.md
Name: clock_monitor

Overview:
- Synthesizable checker for a clock-like signal: the measuring counterpart to the free-running master clock source.
- Samples an external or derived clock (clk_in) as data in the masterclk domain and measures its period and high time in masterclk cycles.
- Tracks the minimum and maximum period, flags periods outside programmable limits, and flags loss of clock.
- Sits between the clock/PLL input and the status register bank.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on clk_in; minimum 2.
- CNT_WIDTH, 16, width of the period/high-time counters and all measurement outputs.
- TIMEOUT, 1000, masterclk cycles without a clk_in rising edge before loss is declared; must be < 2^CNT_WIDTH.

Ports:
- masterclk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clk_in  in  1  monitored signal; asynchronous to masterclk.
- clear  in  1  one-cycle pulse; resets min/max, the sticky loss flag and edge_count.
- lo_limit  in  CNT_WIDTH  lowest acceptable period.
- hi_limit  in  CNT_WIDTH  highest acceptable period.
- period  out  CNT_WIDTH  last measured rise-to-rise period.
- high_time  out  CNT_WIDTH  last measured high phase in cycles.
- period_valid  out  1  one-cycle pulse when period updates.
- period_min  out  CNT_WIDTH  smallest period since clear.
- period_max  out  CNT_WIDTH  largest period since clear.
- out_of_range  out  1  last period < lo_limit or > hi_limit.
- clk_lost  out  1  level; high while in LOST.
- lost_sticky  out  1  set on entry to LOST; cleared only by clear.
- edge_count  out  32  number of rising edges seen; wraps.

Behaviour:
- Reset values:
  - period, high_time, period_max, edge_count: 0.
  - period_min: all ones.
  - period_valid, out_of_range, clk_lost, lost_sticky: 0.
  - state: IDLE; both counters 0.
- Synchronizer and edge detect:
  - clk_in passes through SYNC_STAGES flops, then one delay flop d.
  - rise = s & ~d; fall = ~s & d, where s is the last synchronizer stage.
  - A clk_in transition produces rise/fall SYNC_STAGES cycles after the sampling edge.
- IDLE (no reference edge yet):
  - cnt held at 0; no timeout.
  - On rise: cnt <= 1, go to MEASURE. No period_valid is produced.
- MEASURE:
  - cnt increments each cycle, saturating at all ones.
  - On rise:
    - period <= cnt; period_valid = 1 in the next cycle.
    - cnt <= 1.
    - out_of_range <= (cnt < lo_limit) | (cnt > hi_limit).
    - period_min/period_max update with cnt.
  - A clk_in of period N masterclk cycles gives period = N.
  - If cnt == TIMEOUT and there is no rise this cycle: go to LOST; clk_lost = 1; lost_sticky = 1; cnt <= 0.
  - If rise and timeout occur in the same cycle, rise wins.
- LOST:
  - clk_lost = 1; cnt held at 0.
  - On rise: go to MEASURE with cnt <= 1; clk_lost drops the next cycle; no period_valid for this edge.
  - period, high_time and out_of_range hold their last values.
- High time:
  - hcnt <= 1 on rise, increments while s = 1, saturates.
  - On fall: high_time <= hcnt.
  - In IDLE, high_time is not updated.
- edge_count increments on every rise in every state, wraps 2^32-1 -> 0.
- clear:
  - Sets period_min = all ones, period_max = 0, lost_sticky = 0, edge_count = 0.
  - If a period update occurs in the same cycle, min/max/edge_count take the post-clear value including the new sample: min = max = new period, edge_count = 1.
  - A loss event in the same cycle as clear wins: lost_sticky = 1.
- lo_limit/hi_limit are sampled only at the update cycle; changing them does not re-evaluate the held out_of_range.
- reset_n asserted mid-measurement returns everything to reset values immediately (async).
  - Deassertion is synchronised externally; the first rise after reset is treated as an IDLE edge.

Test Plan:
- clk_in period 20 masterclk cycles, 50% duty, 5 edges -> first edge gives no valid pulse; then 4 period_valid pulses with period = 20, high_time = 10, edge_count = 5, min = max = 20.
- lo_limit = 18, hi_limit = 22; periods 20, 25, 15 -> out_of_range 0, 1, 1; min = 15, max = 25.
- TIMEOUT = 100; stop clk_in high after an edge -> clk_lost and lost_sticky rise exactly 100 cycles after the last cnt <= 1; restart -> clk_lost falls one cycle after the first new rise; next valid period is correct; lost_sticky stays 1 until clear.
- clear pulse in the same cycle as a period = 30 update -> period_min = period_max = 30, edge_count = 1.
- reset_n low for 3 cycles mid-period, then clk_in period 8 -> all outputs at reset values during reset; the first post-reset rise gives no valid pulse; the second gives period = 8.
- TIMEOUT = 1000 with a single long period of 1000: the rise lands in the timeout cycle -> period = 1000, clk_lost stays 0.
